adxl362_spi_ctrl: RTL and testbench

ADXL362_SPI_CTRL -- requirements
Module: adxl362_spi_ctrl

---
 rtl/adxl362_spi_ctrl.sv | 151 +++++++++++++++
 tb/tb_adxl362_spi_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_spi_ctrl.sv
// +----------------------------------------------------------------------------+
// | adxl362_spi_ctrl : SPI mode-0 slave bridging write/read commands to a regfile |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module adxl362_spi_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_16mhz,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [5:0] address,
  output logic       write,
  output logic [7:0] data_write,
  input  logic [7:0] data_read,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    WR_DATA = 3'd3,
    RD_DATA = 3'd4,
    IGNORE  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev, cs_prev;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic       active, byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] rx, rx_next, tx;
  logic       rd_flag, wr_sched, inc_pend, ld_pend;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign active    = (state != IDLE) && !cs_s;
  assign byte_done = active && sclk_rise && (bit_cnt == 3'd7);
  assign rx_next   = {rx[6:0], mosi_s};
  assign busy      = ~cs_s;

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = CMD;
        CMD:     if (byte_done)
                   state_next = (rx_next == CMD_WRITE || rx_next == CMD_READ) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_next = rd_flag ? RD_DATA : WR_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      rx         <= 8'h00;
      tx         <= 8'h00;
      miso       <= 1'b0;
      address    <= 6'h00;
      data_write <= 8'h00;
      write      <= 1'b0;
      rd_flag    <= 1'b0;
      wr_sched   <= 1'b0;
      inc_pend   <= 1'b0;
      ld_pend    <= 1'b0;
    end else begin
      if (!active) begin
        bit_cnt <= 3'd0;
        rx      <= 8'h00;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx      <= rx_next;
      end

      if (state == CMD && byte_done)
        rd_flag <= (rx_next == CMD_READ);

      // Write pulse pipeline runs to completion even if cs_n rises meanwhile.
      wr_sched <= (state == WR_DATA) && byte_done;
      write    <= wr_sched;
      inc_pend <= write;

      if (state == WR_DATA && byte_done)
        data_write <= rx_next;

      if (state == ADDR && byte_done)
        address <= rx_next[5:0];
      else if ((state == RD_DATA && byte_done) || inc_pend)
        address <= address + 6'd1;

      // tx reloads the cycle after address settles on entry and per read byte.
      ld_pend <= ((state == ADDR) && byte_done && rd_flag) ||
                 ((state == RD_DATA) && byte_done);

      if (ld_pend) begin
        tx <= data_read;
      end else if (state == RD_DATA && !cs_s && sclk_fall) begin
        tx <= {tx[6:0], 1'b0};
      end

      if (state == RD_DATA && !cs_s) begin
        if (sclk_fall) miso <= tx[7];
      end else begin
        miso <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adxl362_spi_ctrl.sv
// Scoreboard bench for adxl362_spi_ctrl: SPI master stimulus, regfile model, write/read monitors.
`timescale 1ns/1ps
`default_nettype none

module tb_adxl362_spi_ctrl;

  localparam int HALF = 500;

  logic       clk_16mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sclk      = 1'b0;
  logic       cs_n      = 1'b1;
  logic       mosi      = 1'b0;
  logic       miso;
  logic [5:0] address;
  logic       write;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       busy;

  adxl362_spi_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_16mhz (clk_16mhz),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .address   (address),
    .write     (write),
    .data_write(data_write),
    .data_read (data_read),
    .busy      (busy)
  );

  always #31.25 clk_16mhz = ~clk_16mhz;

  // External register file seen by the DUT, and the bench's own expectation of it.
  logic [7:0]  mem       [64];
  logic [7:0]  model_mem [64];
  logic [7:0]  payload   [4];
  logic [13:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [5:0]  model_addr;
  logic        rd_active = 1'b0;
  logic        miso_free = 1'b0;
  logic [7:0]  rd_sh = 8'h00;
  int          rd_n = 0;
  int          tests = 0;
  int          fails = 0;

  assign data_read = mem[address];
  always @(posedge write) mem[address] = data_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every cycle with write high must match the next expected pulse.
  always @(negedge clk_16mhz) begin
    if (rst_n && write) begin
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL write_unexpected: got addr=%0h data=%0h expected no pulse", address, data_write);
      end else begin
        check("write_pulse", 32'({address, data_write}), 32'(exp_wr.pop_front()));
      end
    end
  end

  // Read monitor: master samples miso on sclk rising edges.
  always @(posedge sclk) begin
    if (rd_active) begin
      rd_sh = {rd_sh[6:0], miso};
      rd_n++;
      if (rd_n == 8) begin
        rd_n = 0;
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL read_unexpected: got %0h expected no byte", rd_sh);
        end else begin
          check("read_byte", 32'(rd_sh), 32'(exp_rd.pop_front()));
        end
      end
    end else if (!miso_free && rst_n) begin
      check("miso_quiet", 32'(miso), 32'd0);
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    cs_n = 1'b1;
    mosi = 1'b0;
    #(4*HALF);
  endtask

  task automatic wr_txn(input logic [7:0] ab, input int n);
    logic [5:0] ea;
    cs_low();
    spi_bits(8'h0A, 8);
    check("busy_active", 32'(busy), 32'd1);
    spi_bits(ab, 8);
    for (int i = 0; i < n; i++) begin
      ea = ab[5:0] + 6'(i);
      exp_wr.push_back({ea, payload[i]});
      model_mem[ea] = payload[i];
      spi_bits(payload[i], 8);
    end
    cs_high();
    model_addr = ab[5:0] + 6'(n);
    check("addr_after_write", 32'(address), 32'(model_addr));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic rd_txn(input logic [7:0] ab, input int n);
    logic [5:0] ea;
    cs_low();
    spi_bits(8'h0B, 8);
    spi_bits(ab, 8);
    for (int i = 0; i < n; i++) begin
      ea = ab[5:0] + 6'(i);
      exp_rd.push_back(model_mem[ea]);
      rd_active = 1'b1;
      spi_bits(8'($urandom), 8);
    end
    rd_active = 1'b0;
    cs_high();
    model_addr = ab[5:0] + 6'(n);
    check("addr_after_read", 32'(address), 32'(model_addr));
  endtask

  task automatic ign_txn(input logic [7:0] cmd, input logic [7:0] ab, input logic [7:0] d);
    cs_low();
    spi_bits(cmd, 8);
    spi_bits(ab, 8);
    spi_bits(d, 8);
    cs_high();
    check("addr_after_ignore", 32'(address), 32'(model_addr));
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] cmd;
    int kind;
    int n;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      mem[i] = v;
      model_mem[i] = v;
    end
    mem[0] = 8'hAD; model_mem[0] = 8'hAD;
    mem[1] = 8'h1D; model_mem[1] = 8'h1D;
    model_addr = 6'h00;

    repeat (3) @(negedge clk_16mhz);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data_write", 32'(data_write), 32'd0);
    rst_n = 1'b1;
    #(4*HALF);

    rd_txn(8'h00, 2);

    payload[0] = 8'h55;
    wr_txn(8'h20, 1);

    payload[0] = 8'h11;
    payload[1] = 8'h22;
    wr_txn(8'h3F, 2);

    ign_txn(8'h0D, 8'h20, 8'hFF);

    // Aborted write: four data bits then cs_n high.
    cs_low();
    spi_bits(8'h0A, 8);
    spi_bits(8'h24, 8);
    spi_bits(8'hA5, 4);
    cs_high();
    model_addr = 6'h24;
    check("partial_addr", 32'(address), 32'(model_addr));
    check("partial_busy", 32'(busy), 32'd0);

    // Reset in the middle of a read data byte.
    cs_low();
    spi_bits(8'h0B, 8);
    spi_bits(8'h05, 8);
    miso_free = 1'b1;
    spi_bits(8'h00, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_16mhz);
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    cs_n = 1'b1;
    repeat (2) @(negedge clk_16mhz);
    rst_n = 1'b1;
    miso_free = 1'b0;
    model_addr = 6'h00;
    #(4*HALF);
    payload[0] = 8'h3C;
    wr_txn(8'h07, 1);
    rd_txn(8'h07, 1);

    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
      if (kind == 0) begin
        wr_txn(8'($urandom), n);
      end else if (kind == 1) begin
        rd_txn(8'($urandom), n);
      end else begin
        cmd = 8'($urandom);
        while (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'($urandom);
        ign_txn(cmd, 8'($urandom), 8'($urandom));
      end
    end

    #(2*HALF);
    check("write_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("read_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
